// File: rtl/input_debounce_pkg.sv
// input_debounce_pkg: shared state encoding and parameter limits for the debouncer.
package input_debounce_pkg;
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;
    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;
endpackage

// File: rtl/input_debounce_sync_chain.sv
// input_debounce_sync_chain: plain multi-flop synchroniser for one asynchronous bit.
module input_debounce_sync_chain #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
    assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/input_debounce.sv
// input_debounce: synchronises a bouncy input and only accepts a new level after it
// has been stable for STABLE_CYCLES enabled cycles; emits rise/fall strobes.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_W         = 16,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    input  logic en,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $error("input_debounce: SYNC_STAGES out of range");
    end
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2**CNT_W) - 1) begin : g_bad_stable
        $error("input_debounce: STABLE_CYCLES does not fit CNT_W");
    end

    logic             s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d, rise_q, rise_d, fall_q, fall_d;

    input_debounce_sync_chain #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_LEVEL(RESET_LEVEL)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (d_in),
        .q    (s)
    );

    // en low freezes everything in both states; only the synchroniser keeps moving
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (en) begin
            if (state_q == IDLE) begin
                if (s != q_q) begin
                    if (STABLE_CYCLES == 1) begin
                        q_d    = s;
                        rise_d = s;
                        fall_d = !s;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = COUNT;
                    end
                end
            end else if (s == q_q) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else if (cnt_q == LAST) begin
                q_d     = s;
                rise_d  = s;
                fall_d  = !s;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == COUNT);
endmodule
